// File: rtl/str_pack_pkg.sv
// Shared types and constants for the string packing scheduler.
// Holds the FSM encoding, field widths and the saturating length increment.
package str_pack_pkg;

    localparam int LEN_W = 16;
    localparam int CHAR_W = 8;
    localparam logic [CHAR_W-1:0] NULL_CHAR = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (v == {LEN_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/str_pack_rr_arb.sv
// Combinational round-robin arbiter: first asserted request at or after rr_ptr, with wrap.
// The caller registers the grant; nothing here holds state.
module str_pack_rr_arb
    import str_pack_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant_oh,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    localparam int CW = IDW + 1;

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [CW-1:0]     offset;
    logic [CW-1:0]     idx_sum;
    logic [CW-1:0]     idx_wrap;

    // Rotating a doubled copy puts the requester at rr_ptr on bit 0.
    assign req_dbl   = {req, req};
    assign req_rot   = req_dbl[rr_ptr +: NREQ];
    assign grant_any = |req;

    always_comb begin
        offset = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset = CW'(k);
            end
        end
    end

    assign idx_sum   = {1'b0, rr_ptr} + offset;
    assign idx_wrap  = (idx_sum >= CW'(NREQ)) ? idx_sum - CW'(NREQ) : idx_sum;
    assign grant_idx = idx_wrap[IDW-1:0];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_oh
            assign grant_oh[gi] = grant_any && (idx_wrap == CW'(gi));
        end
    endgenerate

endmodule

// File: rtl/str_pack_sched.sv
// Shares one string-to-bit packer among NREQ requesters with round-robin grants.
// Each granted string is packed right-aligned (newest character in the LSBs) and emitted with its requester ID.
module str_pack_sched
    import str_pack_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2,
    parameter int IDW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*CHAR_W-1:0]   req_char,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [IDW-1:0]           out_id,
    output logic [LEN_W-1:0]         out_len,
    output logic                     out_trunc
);

    state_t               state_reg;
    logic [IDW-1:0]       grant_reg;
    logic [IDW-1:0]       rr_ptr_reg;
    logic [WIDTH-1:0]     acc_reg;
    logic [LEN_W-1:0]     len_reg;
    logic [NREQ-1:0]      req_ready_reg;
    logic                 out_valid_reg;

    logic [NREQ-1:0]      arb_oh;
    logic [IDW-1:0]       arb_idx;
    logic                 arb_any;

    logic                 beat;
    logic                 cur_last;
    logic [CHAR_W-1:0]    cur_char;
    logic [WIDTH-1:0]     acc_next;
    logic [IDW-1:0]       rr_ptr_next;

    str_pack_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_reg),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    // req_ready_reg is one-hot on the granted requester, so it doubles as the data mux select.
    always_comb begin
        cur_char = '0;
        for (int i = 0; i < NREQ; i++) begin
            cur_char = cur_char | (req_char[CHAR_W*i +: CHAR_W] & {CHAR_W{req_ready_reg[i]}});
        end
    end

    assign beat     = (state_reg == ST_COLLECT) && |(req_valid & req_ready_reg);
    assign cur_last = |(req_last & req_ready_reg);

    generate
        if (WIDTH > CHAR_W) begin : g_shift_wide
            assign acc_next = {acc_reg[WIDTH-CHAR_W-1:0], cur_char};
        end else begin : g_shift_byte
            assign acc_next = cur_char;
        end
    endgenerate

    assign rr_ptr_next = (grant_reg == IDW'(NREQ - 1)) ? '0 : grant_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= '0;
            rr_ptr_reg    <= '0;
            acc_reg       <= '0;
            len_reg       <= '0;
            req_ready_reg <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant_reg     <= arb_idx;
                        req_ready_reg <= arb_oh;
                        acc_reg       <= '0;
                        len_reg       <= '0;
                        state_reg     <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (beat) begin
                        // Nulls are consumed so an empty string can still carry req_last.
                        if (cur_char != NULL_CHAR) begin
                            acc_reg <= acc_next;
                            len_reg <= sat_inc(len_reg);
                        end
                        if (cur_last) begin
                            req_ready_reg <= '0;
                            out_valid_reg <= 1'b1;
                            rr_ptr_reg    <= rr_ptr_next;
                            state_reg     <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = acc_reg;
    assign out_id    = grant_reg;
    assign out_len   = len_reg;
    assign out_trunc = (len_reg > LEN_W'(WIDTH / CHAR_W));

endmodule

// File: tb/tb_str_pack_sched.sv
// Bench for str_pack_sched: a 32-bit and a 56-bit instance share all stimulus.
// Expected words come from a queue-based model of the string-to-bit cast.
module tb_str_pack_sched;

    localparam int NREQ = 2;

    typedef logic [7:0] bq_t[$];

    typedef struct packed {
        logic [7:0]  id32;
        logic [7:0]  id56;
        logic [31:0] d32;
        logic [55:0] d56;
        logic [15:0] len32;
        logic [15:0] len56;
        logic        tr32;
        logic        tr56;
    } word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_last;
    logic [NREQ*8-1:0] req_char;
    logic              out_ready;

    logic [NREQ-1:0] req_ready32, req_ready56;
    logic            out_valid32, out_valid56;
    logic [31:0]     out_data32;
    logic [55:0]     out_data56;
    logic [0:0]      out_id32, out_id56;
    logic [15:0]     out_len32, out_len56;
    logic            out_trunc32, out_trunc56;

    logic       drv_valid [NREQ];
    logic       drv_last  [NREQ];
    logic [7:0] drv_char  [NREQ];

    int    checks = 0;
    int    failures = 0;
    logic  valid_before_last;
    word_t obs_q[$];

    str_pack_sched #(.WIDTH(32), .NREQ(NREQ)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_char(req_char), .req_last(req_last), .req_ready(req_ready32),
        .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32),
        .out_id(out_id32), .out_len(out_len32), .out_trunc(out_trunc32)
    );

    str_pack_sched #(.WIDTH(56), .NREQ(NREQ)) u_dut56 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_char(req_char), .req_last(req_last), .req_ready(req_ready56),
        .out_valid(out_valid56), .out_ready(out_ready), .out_data(out_data56),
        .out_id(out_id56), .out_len(out_len56), .out_trunc(out_trunc56)
    );

    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_char  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = drv_valid[i];
            req_last[i]        = drv_last[i];
            req_char[8*i +: 8] = drv_char[i];
        end
    end

    // Capture every completed output handshake; one line per transaction.
    always @(negedge clk) begin
        if (rst_n && out_valid32 && out_ready) begin
            obs_q.push_back(word_t'({8'(out_id32), 8'(out_id56), out_data32, out_data56,
                                     out_len32, out_len56, out_trunc32, out_trunc56}));
            $display("txn id=%0d data32=%h data56=%h len=%0d trunc32=%0b",
                     out_id32, out_data32, out_data56, out_len32, out_trunc32);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Reference: drop nulls, keep the newest bytes right-aligned, zero on the left.
    function automatic word_t model(input int id, input bq_t s);
        word_t w;
        bq_t   kept;
        int    k;
        w = '0;
        foreach (s[i]) if (s[i] != 8'h00) kept.push_back(s[i]);
        k = kept.size();
        w.id32  = 8'(id);
        w.id56  = 8'(id);
        w.len32 = (k > 65535) ? 16'hFFFF : 16'(k);
        w.len56 = w.len32;
        for (int p = 0; p < 7 && p < k; p++) begin
            if (p < 4) w.d32[8*p +: 8] = kept[k-1-p];
            w.d56[8*p +: 8] = kept[k-1-p];
        end
        w.tr32 = (k > 4);
        w.tr56 = (k > 7);
        return w;
    endfunction

    // Streams one string; wait0 counts not-ready cycles before the first beat, waitn after it.
    task automatic send(input int id, input bq_t s, input int stall_at, input int stall_len,
                        output int wait0, output int waitn);
        int n;
        wait0 = 0;
        waitn = 0;
        for (int i = 0; i < s.size(); i++) begin
            if (i == stall_at) begin
                drv_valid[id] = 1'b0;
                repeat (stall_len) @(posedge clk);
                #1;
            end
            drv_valid[id] = 1'b1;
            drv_char[id]  = s[i];
            drv_last[id]  = (i == s.size() - 1);
            n = 0;
            @(negedge clk);
            while (req_ready32[id] !== 1'b1 && n < 200) begin
                n++;
                @(negedge clk);
            end
            if (n >= 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout req=%0d idx=%0d got_ready=0 want_ready=1", id, i);
                drv_valid[id] = 1'b0;
                drv_last[id]  = 1'b0;
                return;
            end
            if (i == 0) wait0 = n;
            else if (i != stall_at) waitn += n;
            if (i == s.size() - 1) valid_before_last = out_valid32;
            @(posedge clk);
            #1;
        end
        drv_valid[id] = 1'b0;
        drv_last[id]  = 1'b0;
    endtask

    task automatic wait_word(output word_t w, output bit ok);
        int c = 0;
        ok = 1'b0;
        w  = '0;
        while (obs_q.size() == 0 && c < 300) begin
            c++;
            @(negedge clk);
        end
        if (obs_q.size() != 0) begin
            w  = obs_q.pop_front();
            ok = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) begin
            drv_valid[i] = 1'b0;
            drv_last[i]  = 1'b0;
            drv_char[i]  = 8'h00;
        end
        out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready32, out_valid32, out_data32, out_id32, out_len32, out_trunc32} !== '0) begin
            failures++;
            $display("FAIL reset_out32 got=%h want=0",
                     {req_ready32, out_valid32, out_data32, out_id32, out_len32, out_trunc32});
        end
        checks++;
        if ({req_ready56, out_valid56, out_data56, out_id56, out_len56, out_trunc56} !== '0) begin
            failures++;
            $display("FAIL reset_out56 got=%h want=0",
                     {req_ready56, out_valid56, out_data56, out_id56, out_len56, out_trunc56});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_fairness_first();
        bq_t a = str2q("ab");
        bq_t b = str2q("cd");
        int w0a, wna, w0b, wnb;
        word_t got, exp;
        bit ok;
        fork
            send(0, a, -1, 0, w0a, wna);
            send(1, b, -1, 0, w0b, wnb);
        join
        wait_word(got, ok);
        exp = model(0, a);
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL fair_first0 got=%h want=%h ok=%0d", got, exp, ok);
        end
        wait_word(got, ok);
        exp = model(1, b);
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL fair_first1 got=%h want=%h ok=%0d", got, exp, ok);
        end
    endtask

    task automatic test_short();
        bq_t s = str2q("sm");
        int w0, wn;
        word_t got, exp;
        bit ok;
        send(0, s, -1, 0, w0, wn);
        checks++;
        if (out_valid32 !== 1'b1 || req_ready32 !== '0 || valid_before_last !== 1'b0) begin
            failures++;
            $display("FAIL short_timing got=valid%0b ready%b before%0b want=valid1 ready00 before0",
                     out_valid32, req_ready32, valid_before_last);
        end
        checks++;
        if (w0 != 1 || wn != 0) begin
            failures++;
            $display("FAIL short_latency got=w0:%0d wn:%0d want=w0:1 wn:0", w0, wn);
        end
        wait_word(got, ok);
        exp = model(0, s);
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL short_word got=%h want=%h ok=%0d", got, exp, ok);
        end
        checks++;
        if (got.d32 !== 32'h0000736d || got.len32 !== 16'd2 || got.tr32 !== 1'b0 || got.id32 !== 8'd0) begin
            failures++;
            $display("FAIL short_literal got=%h/%0d/%0b want=0000736d/2/0", got.d32, got.len32, got.tr32);
        end
    endtask

    task automatic test_trunc();
        bq_t s1 = str2q("medium");
        bq_t s2 = str2q("veryverylongwilltruncate");
        int w0, wn;
        word_t got, exp;
        bit ok;
        send(0, s1, -1, 0, w0, wn);
        wait_word(got, ok);
        exp = model(0, s1);
        checks++;
        if (!ok || got !== exp || got.d32 !== 32'h6469756d || got.len32 !== 16'd6 || got.tr32 !== 1'b1) begin
            failures++;
            $display("FAIL trunc_medium got=%h want=%h ok=%0d", got, exp, ok);
        end
        send(1, s2, -1, 0, w0, wn);
        wait_word(got, ok);
        exp = model(1, s2);
        checks++;
        if (!ok || got !== exp || got.d56 !== 56'h72756e63617465 || got.len56 !== 16'd24) begin
            failures++;
            $display("FAIL trunc_long got=%h want=%h ok=%0d", got, exp, ok);
        end
    endtask

    task automatic test_null();
        bq_t e = '{8'h00};
        bq_t z = '{8'h7a, 8'h00, 8'h6d, 8'h65, 8'h64, 8'h69};
        int w0, wn;
        word_t got, exp;
        bit ok;
        send(0, e, -1, 0, w0, wn);
        wait_word(got, ok);
        exp = model(0, e);
        checks++;
        if (!ok || got !== exp || got.d32 !== 32'h0 || got.len32 !== 16'd0) begin
            failures++;
            $display("FAIL null_empty got=%h want=%h ok=%0d", got, exp, ok);
        end
        send(1, z, -1, 0, w0, wn);
        wait_word(got, ok);
        exp = model(1, z);
        checks++;
        if (!ok || got !== exp || got.d32 !== 32'h6d656469 || got.len32 !== 16'd5) begin
            failures++;
            $display("FAIL null_mid got=%h want=%h ok=%0d", got, exp, ok);
        end
    endtask

    task automatic test_fairness_repeat();
        for (int r = 0; r < 4; r++) begin
            bq_t a, b;
            int w0a, wna, w0b, wnb;
            word_t got, exp;
            bit ok;
            for (int i = 0; i < 1 + $urandom_range(0, 5); i++) a.push_back(8'($urandom_range(1, 255)));
            for (int i = 0; i < 1 + $urandom_range(0, 5); i++) b.push_back(8'($urandom_range(1, 255)));
            fork
                send(0, a, -1, 0, w0a, wna);
                send(1, b, -1, 0, w0b, wnb);
            join
            wait_word(got, ok);
            exp = model(0, a);
            checks++;
            if (!ok || got !== exp) begin
                failures++;
                $display("FAIL fair_rep%0d_first got=%h want=%h ok=%0d", r, got, exp, ok);
            end
            wait_word(got, ok);
            exp = model(1, b);
            checks++;
            if (!ok || got !== exp) begin
                failures++;
                $display("FAIL fair_rep%0d_second got=%h want=%h ok=%0d", r, got, exp, ok);
            end
        end
    endtask

    task automatic test_backpressure();
        bq_t s = str2q("hello");
        int w0, wn;
        word_t got, exp;
        bit ok;
        exp = model(0, s);
        out_ready = 1'b0;
        send(0, s, -1, 0, w0, wn);
        drv_valid[1] = 1'b1;
        drv_char[1]  = 8'h55;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid32 !== 1'b1 || out_data32 !== exp.d32 || out_len32 !== exp.len32 || req_ready32 !== '0) begin
                failures++;
                $display("FAIL bp_hold%0d got=v%0b d%h r%b want=v1 d%h r00",
                         k, out_valid32, out_data32, req_ready32, exp.d32);
            end
        end
        @(posedge clk);
        #1;
        drv_valid[1] = 1'b0;
        out_ready = 1'b1;
        wait_word(got, ok);
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL bp_word got=%h want=%h ok=%0d", got, exp, ok);
        end
    endtask

    task automatic test_stall();
        bq_t s = str2q("stalled!");
        int w0, wn;
        word_t got, exp;
        bit ok;
        send(1, s, 3, 3, w0, wn);
        wait_word(got, ok);
        exp = model(1, s);
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL stall_word got=%h want=%h ok=%0d", got, exp, ok);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            bq_t s;
            int id, n, sa, sl, w0, wn;
            word_t got, exp;
            bit ok;
            id = $urandom_range(0, NREQ - 1);
            n  = $urandom_range(0, 12);
            if (n == 0) s.push_back(8'h00);
            for (int i = 0; i < n; i++)
                s.push_back(($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
            sa = (n > 2) ? $urandom_range(1, n - 1) : -1;
            sl = $urandom_range(1, 4);
            send(id, s, sa, sl, w0, wn);
            wait_word(got, ok);
            exp = model(id, s);
            checks++;
            if (!ok || got !== exp || w0 != 1 || wn != 0) begin
                failures++;
                $display("FAIL rand%0d got=%h want=%h ok=%0d w0=%0d wn=%0d", it, got, exp, ok, w0, wn);
            end
        end
    endtask

    task automatic test_reset_collect();
        bq_t q = str2q("q");
        bq_t a = str2q("ab");
        bq_t b = str2q("cd");
        int w0, wn, w0b, wnb, n;
        word_t got, exp;
        bit ok;
        send(0, q, -1, 0, w0, wn);
        wait_word(got, ok);
        drv_valid[1] = 1'b1;
        drv_char[1]  = 8'h41;
        drv_last[1]  = 1'b0;
        n = 0;
        while (req_ready32[1] !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready32, out_valid32, out_data32, out_id32, out_len32, out_trunc32,
             req_ready56, out_valid56, out_data56, out_id56, out_len56, out_trunc56} !== '0 || n >= 50) begin
            failures++;
            $display("FAIL rst_collect got=r%b d%h l%0d n%0d want=0", req_ready32, out_data32, out_len32, n);
        end
        drv_valid[1] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        fork
            send(0, a, -1, 0, w0, wn);
            send(1, b, -1, 0, w0b, wnb);
        join
        wait_word(got, ok);
        exp = model(0, a);
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL rst_collect_next0 got=%h want=%h ok=%0d", got, exp, ok);
        end
        wait_word(got, ok);
        exp = model(1, b);
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL rst_collect_next1 got=%h want=%h ok=%0d", got, exp, ok);
        end
    endtask

    task automatic test_reset_emit();
        bq_t s = str2q("xyz");
        bq_t k = str2q("k");
        int w0, wn;
        word_t got, exp;
        bit ok;
        out_ready = 1'b0;
        send(1, s, -1, 0, w0, wn);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready32, out_valid32, out_data32, out_id32, out_len32, out_trunc32} !== '0) begin
            failures++;
            $display("FAIL rst_emit32 got=v%0b d%h l%0d want=0", out_valid32, out_data32, out_len32);
        end
        checks++;
        if ({req_ready56, out_valid56, out_data56, out_id56, out_len56, out_trunc56} !== '0) begin
            failures++;
            $display("FAIL rst_emit56 got=v%0b d%h l%0d want=0", out_valid56, out_data56, out_len56);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL rst_emit_dropped got=%0d want=0", obs_q.size());
        end
        @(posedge clk);
        #1;
        send(1, k, -1, 0, w0, wn);
        wait_word(got, ok);
        exp = model(1, k);
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL rst_emit_next got=%h want=%h ok=%0d", got, exp, ok);
        end
    endtask

    initial begin
        test_reset();
        test_fairness_first();
        test_short();
        test_trunc();
        test_null();
        test_fairness_repeat();
        test_backpressure();
        test_stall();
        test_random();
        test_reset_collect();
        test_reset_emit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
